// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 hex keypad scanner.
//   state_t     - scanner FSM states
//   KEY_W       - bits per hex key code / display digit
//   ROWS, COLS  - keypad matrix dimensions
//   NUM_DIGITS  - digits held in the assembled number (digit counter saturates here)
//   col_decode  - maps an active-low column word to (valid, lowest low column index)
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_t;

    localparam int unsigned KEY_W      = 4;
    localparam int unsigned ROWS       = 4;
    localparam int unsigned COLS       = 4;
    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned ROW_W      = 2;
    localparam int unsigned COL_W      = 2;

    typedef struct packed {
        logic             valid;
        logic [COL_W-1:0] idx;
    } col_hit_t;

    // Lowest-numbered low column wins when several are pressed together.
    function automatic col_hit_t col_decode(input logic [COLS-1:0] c);
        col_hit_t h;
        h.valid = 1'b0;
        h.idx   = '0;
        for (int unsigned i = 0; i < COLS; i++) begin
            if (!c[i] && !h.valid) begin
                h.valid = 1'b1;
                h.idx   = COL_W'(i);
            end
        end
        return h;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: width-parameterised two-flop synchroniser.
// Ports:
//   i_clk   - destination clock
//   i_rst_n - asynchronous active-low reset; both stages load RST_VAL
//   i_d     - asynchronous input
//   o_q     - synchronised output (two clock edges of latency)
module sync_2ff #(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RST_VAL;
            r_q    <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low hex keypad, debounces presses and
// releases, and shifts accepted key codes into a 32-bit number (8 hex digits).
// Ports:
//   clock       - system clock
//   reset       - asynchronous active-low reset
//   col         - keypad columns, active-low, asynchronous to clock
//   clear       - synchronous clear of num and digit_count (FSM untouched)
//   row         - keypad rows, active-low, exactly one low
//   num         - assembled number, newest digit in num[3:0]
//   key_code    - code of the last accepted key (row*4 + col)
//   key_valid   - one-cycle strobe per accepted press
//   digit_count - digits entered since clear, saturating at 8
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned DEBOUNCE_CNT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  col,
    input  logic        clear,
    output logic [3:0]  row,
    output logic [31:0] num,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic [3:0]  digit_count
);

    localparam int unsigned TMR_W = $clog2(SCAN_DIV);
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CNT + 1);

    logic [COLS-1:0]  w_col_s;
    col_hit_t         w_hit;
    logic [KEY_W-1:0] w_code;
    logic             w_sample;

    logic [TMR_W-1:0] r_timer;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [ROW_W-1:0] r_row_idx;
    logic [ROW_W-1:0] w_row_idx_nxt;
    logic [ROWS-1:0]  r_row;
    logic [ROWS-1:0]  w_row_nxt;
    logic [KEY_W-1:0] r_cand;
    logic [KEY_W-1:0] w_cand_nxt;
    logic [DB_W-1:0]  r_db_cnt;
    logic [DB_W-1:0]  w_db_cnt_nxt;
    logic             w_accept;

    logic [31:0]      r_num;
    logic [KEY_W-1:0] r_key_code;
    logic             r_key_valid;
    logic [3:0]       r_digits;

    sync_2ff #(
        .WIDTH   (COLS),
        .RST_VAL (4'b1111)
    ) u_col_sync (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_d     (col),
        .o_q     (w_col_s)
    );

    assign w_hit    = col_decode(w_col_s);
    assign w_code   = {r_row_idx, w_hit.idx};
    assign w_sample = (r_timer == TMR_W'(SCAN_DIV - 1));

    // Free-running sample timer, independent of FSM state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_timer <= '0;
        end else if (w_sample) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // r_db_cnt doubles as the press-match count in DEBOUNCE and the
    // release count in HELD; it is zeroed on every transition into HELD/SCAN.
    always_comb begin
        w_state_nxt   = r_state;
        w_row_idx_nxt = r_row_idx;
        w_row_nxt     = r_row;
        w_cand_nxt    = r_cand;
        w_db_cnt_nxt  = r_db_cnt;
        w_accept      = 1'b0;
        if (w_sample) begin
            unique case (r_state)
                SCAN: begin
                    if (!w_hit.valid) begin
                        w_row_idx_nxt = r_row_idx + 1'b1;
                        w_row_nxt     = {r_row[ROWS-2:0], r_row[ROWS-1]};
                    end else begin
                        w_cand_nxt   = w_code;
                        w_db_cnt_nxt = DB_W'(1);
                        w_state_nxt  = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (w_hit.valid && (w_code == r_cand)) begin
                        if (r_db_cnt == DB_W'(DEBOUNCE_CNT - 1)) begin
                            w_accept     = 1'b1;
                            w_db_cnt_nxt = '0;
                            w_state_nxt  = HELD;
                        end else begin
                            w_db_cnt_nxt = r_db_cnt + 1'b1;
                        end
                    end else begin
                        w_row_idx_nxt = r_row_idx + 1'b1;
                        w_row_nxt     = {r_row[ROWS-2:0], r_row[ROWS-1]};
                        w_db_cnt_nxt  = '0;
                        w_state_nxt   = SCAN;
                    end
                end
                HELD: begin
                    if (!w_hit.valid) begin
                        if (r_db_cnt == DB_W'(DEBOUNCE_CNT - 1)) begin
                            w_row_idx_nxt = r_row_idx + 1'b1;
                            w_row_nxt     = {r_row[ROWS-2:0], r_row[ROWS-1]};
                            w_db_cnt_nxt  = '0;
                            w_state_nxt   = SCAN;
                        end else begin
                            w_db_cnt_nxt = r_db_cnt + 1'b1;
                        end
                    end else begin
                        w_db_cnt_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = SCAN;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= SCAN;
            r_row_idx <= '0;
            r_row     <= 4'b1110;
            r_cand    <= '0;
            r_db_cnt  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_row_idx <= w_row_idx_nxt;
            r_row     <= w_row_nxt;
            r_cand    <= w_cand_nxt;
            r_db_cnt  <= w_db_cnt_nxt;
        end
    end

    // clear beats a coincident accept for num/digit_count, but the strobe
    // and key_code still report the key.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_num       <= '0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_digits    <= '0;
        end else begin
            r_key_valid <= w_accept;
            if (w_accept) begin
                r_key_code <= r_cand;
            end
            if (clear) begin
                r_num    <= '0;
                r_digits <= '0;
            end else if (w_accept) begin
                r_num <= {r_num[31-KEY_W:0], r_cand};
                if (r_digits != 4'(NUM_DIGITS)) begin
                    r_digits <= r_digits + 1'b1;
                end
            end
        end
    end

    assign row         = r_row;
    assign num         = r_num;
    assign key_code    = r_key_code;
    assign key_valid   = r_key_valid;
    assign digit_count = r_digits;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with SCAN_DIV=4 and
// DEBOUNCE_CNT=3. A behavioural keypad drives col low only while the pressed
// key's row is driven low; 'bounce' forces the contact open.
module tb_keypad_scanner;

    logic        clock;
    logic        reset;
    logic [3:0]  col;
    logic        clear;
    logic [3:0]  row;
    logic [31:0] num;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [3:0]  digit_count;

    logic        key_down;
    logic [1:0]  key_r;
    logic [1:0]  key_c;
    logic        bounce;

    int checks;
    int errors;
    int strobes;

    logic [3:0] row_pat [4];

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .col         (col),
        .clear       (clear),
        .row         (row),
        .num         (num),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .digit_count (digit_count)
    );

    assign col = (key_down && !bounce && (row[key_r] == 1'b0)) ? ~(4'b0001 << key_c) : 4'b1111;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (key_valid) strobes++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        step(2);
        reset = 1'b1;
    endtask

    task automatic press_key(input logic [3:0] code);
        logic found;
        found    = 1'b0;
        key_r    = code[3:2];
        key_c    = code[1:0];
        key_down = 1'b1;
        for (int i = 0; i < 200 && !found; i++) begin
            step(1);
            found = key_valid;
        end
        check("press_strobe", {31'd0, found}, 32'd1);
        check("press_code", {28'd0, key_code}, {28'd0, code});
        key_down = 1'b0;
        step(30);
    endtask

    task automatic wait_row(input logic [3:0] want);
        logic seen;
        seen = (row === want);
        for (int i = 0; i < 64 && !seen; i++) begin
            step(1);
            seen = (row === want);
        end
        check("wait_row", {28'd0, row}, {28'd0, want});
    endtask

    initial begin
        int s0;
        checks   = 0;
        errors   = 0;
        strobes  = 0;
        reset    = 1'b0;
        clear    = 1'b0;
        key_down = 1'b0;
        key_r    = 2'd0;
        key_c    = 2'd0;
        bounce   = 1'b0;
        row_pat  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        // 1: idle scanning
        do_reset();
        check("rst_row", {28'd0, row}, 32'h0000000e);
        check("rst_num", num, 32'd0);
        for (int k = 1; k <= 20; k++) begin
            step(1);
            check("idle_row", {28'd0, row}, {28'd0, row_pat[(k / 4) % 4]});
            check("idle_valid", {31'd0, key_valid}, 32'd0);
        end
        check("idle_num", num, 32'd0);

        // 2: press row 1 / col 2 from reset, hold 100 cycles
        key_r = 2'd1; key_c = 2'd2; key_down = 1'b1;
        do_reset();
        s0 = strobes;
        step(15);
        check("k6_early", {31'd0, key_valid}, 32'd0);
        step(1);
        check("k6_valid", {31'd0, key_valid}, 32'd1);
        check("k6_code", {28'd0, key_code}, 32'd6);
        check("k6_num", num, 32'h00000006);
        check("k6_count", {28'd0, digit_count}, 32'd1);
        step(1);
        check("k6_pulse_end", {31'd0, key_valid}, 32'd0);
        step(83);
        check("k6_one_strobe", strobes - s0, 32'd1);
        key_down = 1'b0;
        step(11);
        check("k6_rel_hold", {28'd0, row}, 32'h0000000d);
        step(1);
        check("k6_rel_adv", {28'd0, row}, 32'h0000000b);

        // 3: keys 1..9 after clear, digit count saturation
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("clr_num", num, 32'd0);
        check("clr_count", {28'd0, digit_count}, 32'd0);
        for (int k = 1; k <= 8; k++) press_key(4'(k));
        check("n8_num", num, 32'h12345678);
        check("n8_count", {28'd0, digit_count}, 32'd8);
        press_key(4'd9);
        check("n9_num", num, 32'h23456789);
        check("n9_count", {28'd0, digit_count}, 32'd8);

        // 4: bounce during debounce, then clean re-detection
        key_r = 2'd1; key_c = 2'd2; key_down = 1'b1;
        do_reset();
        s0 = strobes;
        step(9);
        bounce = 1'b1;
        step(3);
        check("bnc_row_adv", {28'd0, row}, 32'h0000000b);
        bounce = 1'b0;
        step(23);
        check("bnc_no_strobe", strobes - s0, 32'd0);
        check("bnc_early", {31'd0, key_valid}, 32'd0);
        step(1);
        check("bnc_valid", {31'd0, key_valid}, 32'd1);
        check("bnc_code", {28'd0, key_code}, 32'd6);
        check("bnc_num", num, 32'h00000006);
        key_down = 1'b0;
        step(30);

        // 5: clear coincident with accept of key F
        do_reset();
        press_key(4'd1);
        press_key(4'd2);
        check("pre_f_num", num, 32'h00000012);
        check("pre_f_count", {28'd0, digit_count}, 32'd2);
        wait_row(4'b1011);
        wait_row(4'b0111);
        key_r = 2'd3; key_c = 2'd3; key_down = 1'b1;
        step(11);
        check("f_early", {31'd0, key_valid}, 32'd0);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("f_valid", {31'd0, key_valid}, 32'd1);
        check("f_code", {28'd0, key_code}, 32'h0000000f);
        check("f_num", num, 32'd0);
        check("f_count", {28'd0, digit_count}, 32'd0);
        step(1);
        check("f_num_hold", num, 32'd0);
        key_down = 1'b0;
        step(30);
        press_key(4'd7);
        check("k7_num", num, 32'h00000007);

        // 6: reset in the middle of DEBOUNCE with the key still held
        wait_row(4'b1110);
        wait_row(4'b1101);
        key_r = 2'd1; key_c = 2'd2; key_down = 1'b1;
        step(6);
        reset = 1'b0;
        #1;
        check("mid_rst_row", {28'd0, row}, 32'h0000000e);
        check("mid_rst_num", num, 32'd0);
        check("mid_rst_code", {28'd0, key_code}, 32'd0);
        check("mid_rst_count", {28'd0, digit_count}, 32'd0);
        check("mid_rst_valid", {31'd0, key_valid}, 32'd0);
        step(3);
        check("mid_rst_row2", {28'd0, row}, 32'h0000000e);
        reset = 1'b1;
        step(15);
        check("re_early", {31'd0, key_valid}, 32'd0);
        step(1);
        check("re_valid", {31'd0, key_valid}, 32'd1);
        check("re_code", {28'd0, key_code}, 32'd6);
        check("re_num", num, 32'h00000006);
        check("re_count", {28'd0, digit_count}, 32'd1);
        key_down = 1'b0;
        step(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "watchdog");
    end

endmodule
